// File: rtl/blueintegral_mm_pkg.sv
// Shared definitions for the 2x2 binary matrix multiplier front end:
// frame width, loader FSM states and operand bit positions.
package blueintegral_mm_pkg;

  localparam int unsigned FRAME_W = 8;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  // Operand positions inside the frame word, A00 is the first beat in.
  localparam int unsigned A00_BIT = 7;
  localparam int unsigned A01_BIT = 6;
  localparam int unsigned A10_BIT = 5;
  localparam int unsigned A11_BIT = 4;
  localparam int unsigned B00_BIT = 3;
  localparam int unsigned B01_BIT = 2;
  localparam int unsigned B10_BIT = 1;
  localparam int unsigned B11_BIT = 0;

endpackage

// File: rtl/blueintegral_mat_loader_if.sv
// Beat input, multiplier loop and result output of the matrix loader.
interface blueintegral_mat_loader_if #(
  parameter int unsigned IN_W = 1
);
  import blueintegral_mm_pkg::*;

  logic                in_valid;
  logic [IN_W-1:0]     in_data;
  logic                in_ready;
  logic [FRAME_W-1:0]  mat_data;
  logic [FRAME_W-1:0]  res_data;
  logic [FRAME_W-1:0]  out_data;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          frame_cnt;

  modport master (
    output in_valid, in_data, res_data, out_ready,
    input  in_ready, mat_data, out_data, out_valid, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, res_data, out_ready,
    output in_ready, mat_data, out_data, out_valid, frame_cnt
  );

endinterface

// File: rtl/blueintegral_shift_collect.sv
// Assembles IN_W-bit beats MSB-first into a FRAME_W-bit frame and tracks
// the beat position so the FSM knows when the frame is complete.
module blueintegral_shift_collect #(
  parameter int unsigned IN_W    = 1,
  parameter int unsigned FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_beat_en,
  input  logic [IN_W-1:0]    i_data,
  output logic               o_last_c,
  output logic [FRAME_W-1:0] o_next_frame_c
);

  localparam int unsigned BEATS = FRAME_W / IN_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [FRAME_W-1:0] r_shift;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [FRAME_W-1:0] w_next;

  // Truncating the concatenation drops the oldest IN_W bits, even when IN_W == FRAME_W.
  assign w_next         = FRAME_W'({r_shift, i_data});
  assign o_next_frame_c = w_next;
  assign o_last_c       = (r_beat_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_beat_cnt <= '0;
    end else if (i_clear) begin
      r_shift    <= '0;
      r_beat_cnt <= '0;
    end else if (i_beat_en) begin
      r_shift    <= w_next;
      r_beat_cnt <= o_last_c ? '0 : r_beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/blueintegral_mat_loader.sv
// Serial operand feeder for the 2x2 binary matrix multiplier: collects a frame,
// holds it on mat_data, captures the multiplier result and hands it off.
module blueintegral_mat_loader #(
  parameter int unsigned IN_W    = 1,
  parameter int unsigned FRAME_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  blueintegral_mat_loader_if.slave  bus
);
  import blueintegral_mm_pkg::*;

  state_e             r_state;
  state_e             w_state_nx;
  logic               r_in_ready;
  logic               w_in_ready_nx;
  logic [FRAME_W-1:0] r_mat_data;
  logic [FRAME_W-1:0] w_mat_data_nx;
  logic [FRAME_W-1:0] r_out_data;
  logic [FRAME_W-1:0] w_out_data_nx;
  logic               r_out_valid;
  logic               w_out_valid_nx;
  logic [7:0]         r_frame_cnt;
  logic [7:0]         w_frame_cnt_nx;

  logic               w_beat_en;
  logic               w_last_c;
  logic [FRAME_W-1:0] w_next_frame_c;

  // r_in_ready is high exactly when the FSM sits in LOAD.
  assign w_beat_en = bus.in_valid & r_in_ready & ~clear;

  blueintegral_shift_collect #(
    .IN_W    (IN_W),
    .FRAME_W (FRAME_W)
  ) u_collect (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clear        (clear),
    .i_beat_en      (w_beat_en),
    .i_data         (bus.in_data),
    .o_last_c       (w_last_c),
    .o_next_frame_c (w_next_frame_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_state_nx;
  end

  // Next state and next values of all registered outputs.
  always_comb begin
    w_state_nx     = r_state;
    w_mat_data_nx  = r_mat_data;
    w_out_data_nx  = r_out_data;
    w_out_valid_nx = r_out_valid;
    w_frame_cnt_nx = r_frame_cnt;
    if (clear) begin
      w_state_nx     = ST_LOAD;
      w_out_valid_nx = 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_beat_en && w_last_c) begin
            w_mat_data_nx = w_next_frame_c;
            w_state_nx    = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          w_out_data_nx  = bus.res_data;
          w_out_valid_nx = 1'b1;
          w_state_nx     = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (bus.out_ready) begin
            w_out_valid_nx = 1'b0;
            w_frame_cnt_nx = r_frame_cnt + 8'd1;
            w_state_nx     = ST_LOAD;
          end
        end
        default: w_state_nx = ST_LOAD;
      endcase
    end
    w_in_ready_nx = (w_state_nx == ST_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_mat_data  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_in_ready  <= w_in_ready_nx;
      r_mat_data  <= w_mat_data_nx;
      r_out_data  <= w_out_data_nx;
      r_out_valid <= w_out_valid_nx;
      r_frame_cnt <= w_frame_cnt_nx;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mat_data  = r_mat_data;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.frame_cnt = r_frame_cnt;

endmodule
